// File: rtl/m_arb_select_pkg.sv
// Shared constants for the two-input arbiter/select block.
// Select encoding matches the downstream 2:1 multiplexer.
package m_arb_select_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/m_arb_select_mux2.sv
// Combinational 2:1 multiplexer: y = a when sel is 0, b when sel is 1.
// Parameterized on data width.
module m_mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/m_arb_select.sv
// Two-input round-robin arbiter with mux select generation and a
// one-entry registered output buffer using a valid/ready handshake.
module m_arb_select
    import m_arb_select_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic             w_a_valid,
    input  logic [WIDTH-1:0] w_a_data,
    output logic             w_a_ready,
    input  logic             w_b_valid,
    input  logic [WIDTH-1:0] w_b_data,
    output logic             w_b_ready,
    output logic             r_sel,
    output logic             r_out_valid,
    output logic [WIDTH-1:0] r_out_data,
    input  logic             w_out_ready
);

    logic             r_last;
    logic             w_load;
    logic             grant_a;
    logic             grant_b;
    logic             grant_any;
    logic [WIDTH-1:0] mux_data;

    // On a tie the channel not granted most recently wins.
    assign grant_a = w_a_valid & (~w_b_valid | (r_last == SEL_B));
    assign grant_b = w_b_valid & (~w_a_valid | (r_last == SEL_A));
    assign grant_any = grant_a | grant_b;

    assign w_load = ~r_out_valid | w_out_ready;

    assign w_a_ready = ~w_rst & w_load & grant_a;
    assign w_b_ready = ~w_rst & w_load & grant_b;

    m_mux2 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .a  (w_a_data),
        .b  (w_b_data),
        .sel(grant_b),
        .y  (mux_data)
    );

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sel       <= SEL_A;
            r_last      <= SEL_B;
        end else if (w_load) begin
            if (grant_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= mux_data;
                r_sel       <= grant_b;
                r_last      <= grant_b;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
